ts_frame_builder: RTL and testbench
===================================

TS_FRAME_BUILDER -- requirements
Module: ts_frame_builder

Interface
REQ-001 SHALL have parameter PERIOD, default 10, meaning CLK_10HZ ticks between frame requests (one frame per second).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hEB, meaning the frame's first byte.
REQ-003 SHALL have port CLK_10HZ  in  1  system 10 Hz clock; all logic on rising edge.
REQ-004 SHALL have port RESET  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port TIMESTAMP  in  24  free-running timestamp from the upstream counter, synchronous to CLK_10HZ.
REQ-006 SHALL have port ENABLE  in  1  frame generation enable.
REQ-007 SHALL have port TX_READY  in  1  downstream accepts byte.
REQ-008 SHALL have port TX_DATA  out  8  frame byte.
REQ-009 SHALL have port TX_VALID  out  1  TX_DATA valid.
REQ-010 SHALL have port TX_LAST  out  1  current byte is the frame's final byte.
REQ-011 SHALL have port OVERRUN  out  1  sticky flag for a dropped frame request.
REQ-012 SHALL have port FRAME_CNT  out  8  count of completed frames.

Function
REQ-013 SHALL run a period counter 0..PERIOD-1 while ENABLE=1, issuing one request on the tick where the count equals PERIOD-1, then wrapping to 0.
REQ-014 SHALL clear and hold the period counter at 0 while ENABLE=0; a frame already in progress SHALL complete.
REQ-015 SHALL implement states IDLE and SEND with a 3-bit byte index 0..4.
REQ-016 On a request in IDLE, SHALL latch TIMESTAMP into a 24-bit snapshot on the same edge, set index 0, and enter SEND; TX_VALID SHALL be 1 from the next edge (1-cycle latency).
REQ-017 SHALL use frame bytes: 0=SYNC_BYTE, 1=snap[23:16], 2=snap[15:8], 3=snap[7:0], 4=XOR of bytes 0..3.
REQ-018 In SEND, SHALL drive TX_VALID=1 and TX_DATA=byte[index], advancing the index on each edge where TX_VALID and TX_READY are both 1.
REQ-019 SHALL hold TX_DATA, TX_LAST and the snapshot stable while TX_VALID=1 and TX_READY=0.
REQ-020 SHALL drive TX_LAST=1 only when in SEND with index 4.
REQ-021 On the handshake of byte 4, SHALL return to IDLE, deassert TX_VALID, and increment FRAME_CNT modulo 256 (255->0).
REQ-022 On a request arriving while in SEND, SHALL set OVERRUN=1, drop the request, and leave the frame in progress and its snapshot unchanged.
REQ-023 SHALL keep OVERRUN set until reset.
REQ-024 On a request coinciding with the byte-4 handshake, SHALL treat the request as overrun; no back-to-back frame.
REQ-025 Outside SEND, SHALL hold TX_VALID=0, TX_LAST=0 and TX_DATA=8'h00.

Reset
REQ-026 On RESET=0, SHALL immediately (asynchronously) force state IDLE, index 0, period counter 0, snapshot 0, TX_DATA=0, TX_VALID=0, TX_LAST=0, OVERRUN=0 and FRAME_CNT=0.
REQ-027 On reset mid-frame, SHALL abandon the partial frame without incrementing FRAME_CNT.
REQ-028 After RESET rises, the first request SHALL occur PERIOD ticks after the release edge, given ENABLE=1.

Structure
REQ-029 SHALL place SYNC_BYTE default, FRAME_LEN=5 and the state encoding (IDLE, SEND) in shared package ts_frame_pkg.
REQ-030 SHALL isolate the period counter and request pulse in sub-module ts_period_tick (ports CLK_10HZ, RESET, ENABLE, TICK).

Verification
REQ-031 PERIOD=10, TIMESTAMP=24'h123456 at request, TX_READY=1 -> bytes EB 12 34 56 9B on 5 consecutive cycles, TX_LAST only on 9B, FRAME_CNT 0->1.
REQ-032 Hold TX_READY=0 for 3 cycles while byte 2 is presented -> TX_DATA holds 8'h34 with TX_VALID=1, and transfer resumes with 8'h56.
REQ-033 Hold TX_READY=0 for 12 cycles from frame start -> OVERRUN=1 at the next request tick, original frame completes intact, FRAME_CNT increments by exactly 1.
REQ-034 Pull RESET low after byte 1 is accepted -> TX_VALID=0 before the next edge, FRAME_CNT=0, and the next frame starts 10 ticks after release.
REQ-035 Hold ENABLE=0 for 30 ticks -> no TX_VALID; re-enable -> first frame after 10 ticks.
REQ-036 Run 256 frames -> FRAME_CNT wraps to 8'h00, OVERRUN=0.

Source files
------------

// File: rtl/ts_frame_pkg.sv
// ts_frame_pkg: shared constants, state encoding and frame byte mux for the timestamp frame builder
package ts_frame_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hEB;
    localparam int         FRAME_LEN    = 5;
    localparam logic [2:0] LAST_IDX     = 3'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SEND} state_t;

    // Byte 4 is the XOR checksum of the sync byte and the three snapshot bytes.
    function automatic logic [7:0] frame_byte(input logic [7:0] sync, input logic [23:0] snap, input logic [2:0] idx);
        logic [7:0] sum;
        sum = sync ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
        return idx == 3'd0 ? sync :
               idx == 3'd1 ? snap[23:16] :
               idx == 3'd2 ? snap[15:8] :
               idx == 3'd3 ? snap[7:0] : sum;
    endfunction

endpackage

// File: rtl/ts_period_tick.sv
// ts_period_tick: period counter that pulses TICK once every PERIOD enabled clocks
module ts_period_tick
    import ts_frame_pkg::*;
#(
    parameter int PERIOD = 10
) (
    input  logic CLK_10HZ,
    input  logic RESET,
    input  logic ENABLE,
    output logic TICK
);

    localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;

    assign TICK = ENABLE && count == CW'(PERIOD - 1);

    // Count while enabled, wrap on the request tick, hold at zero while disabled.
    always_ff @(posedge CLK_10HZ or negedge RESET) begin
        if (!RESET)
            count <= '0;
        else if (!ENABLE || TICK)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/ts_frame_builder.sv
// ts_frame_builder: emits a 5-byte sync/timestamp/checksum frame once per period over a valid/ready byte stream
module ts_frame_builder
    import ts_frame_pkg::*;
#(
    parameter int         PERIOD    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic        CLK_10HZ,
    input  logic        RESET,
    input  logic [23:0] TIMESTAMP,
    input  logic        ENABLE,
    input  logic        TX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    output logic        TX_LAST,
    output logic        OVERRUN,
    output logic [7:0]  FRAME_CNT
);

    state_t      state;
    logic [2:0]  idx;
    logic [23:0] snap;
    logic        tick;

    ts_period_tick #(.PERIOD(PERIOD)) u_tick (
        .CLK_10HZ (CLK_10HZ),
        .RESET    (RESET),
        .ENABLE   (ENABLE),
        .TICK     (tick)
    );

    // Frame sequencer: outputs are registered so the next byte is precomputed on each handshake.
    always_ff @(posedge CLK_10HZ or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            idx       <= '0;
            snap      <= '0;
            TX_DATA   <= '0;
            TX_VALID  <= 1'b0;
            TX_LAST   <= 1'b0;
            OVERRUN   <= 1'b0;
            FRAME_CNT <= '0;
        end else if (state == IDLE) begin
            if (tick) begin
                state    <= SEND;
                idx      <= '0;
                snap     <= TIMESTAMP;
                TX_VALID <= 1'b1;
                TX_DATA  <= SYNC_BYTE;
                TX_LAST  <= 1'b0;
            end
        end else begin
            if (tick)
                OVERRUN <= 1'b1;
            if (TX_READY) begin
                if (idx == LAST_IDX) begin
                    state     <= IDLE;
                    idx       <= '0;
                    TX_VALID  <= 1'b0;
                    TX_DATA   <= '0;
                    TX_LAST   <= 1'b0;
                    FRAME_CNT <= FRAME_CNT + 8'd1;
                end else begin
                    idx     <= idx + 3'd1;
                    TX_DATA <= frame_byte(SYNC_BYTE, snap, idx + 3'd1);
                    TX_LAST <= idx + 3'd1 == LAST_IDX;
                end
            end
        end
    end

endmodule

// File: tb/tb_ts_frame_builder.sv
// tb_ts_frame_builder: directed scoreboard bench for the timestamp frame builder
module tb_ts_frame_builder;

    logic        CLK_10HZ = 1'b0;
    logic        RESET = 1'b0;
    logic [23:0] TIMESTAMP = 24'h123456;
    logic        ENABLE = 1'b0;
    logic        TX_READY = 1'b1;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_LAST;
    logic        OVERRUN;
    logic [7:0]  FRAME_CNT;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    fails = 0;
    int    done = 0;
    int    base = 0;

    always #5 CLK_10HZ = ~CLK_10HZ;

    ts_frame_builder #(.PERIOD(10), .SYNC_BYTE(8'hEB)) dut (
        .CLK_10HZ  (CLK_10HZ),
        .RESET     (RESET),
        .TIMESTAMP (TIMESTAMP),
        .ENABLE    (ENABLE),
        .TX_READY  (TX_READY),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_LAST   (TX_LAST),
        .OVERRUN   (OVERRUN),
        .FRAME_CNT (FRAME_CNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        item_t it;
        it.data = d;
        it.last = l;
        q.push_back(it);
    endtask

    task automatic push_frame(input logic [23:0] ts);
        logic [7:0] b [5];
        b[0] = 8'hEB;
        b[1] = ts[23:16];
        b[2] = ts[15:8];
        b[3] = ts[7:0];
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        for (int i = 0; i < 5; i++)
            push_byte(b[i], i == 4);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge CLK_10HZ);
            n++;
            @(negedge CLK_10HZ);
        end while (!TX_VALID && n < 40);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(posedge CLK_10HZ);
            n++;
            @(negedge CLK_10HZ);
        end while (TX_VALID && n < 40);
    endtask

    initial begin
        int   n;
        logic saw;
        logic [7:0] cnt_before;
        fork
            forever begin
                @(negedge CLK_10HZ);
                if (RESET === 1'b1) begin
                    if (TX_VALID) begin
                        checks++;
                        assert (q.size() > 0) else begin
                            fails++;
                            $error("FAIL sb_underflow: observed byte %0h with empty scoreboard, expected no valid", TX_DATA);
                        end
                        if (q.size() > 0) begin
                            chk("tx_data", 32'(TX_DATA), 32'(q[0].data));
                            chk("tx_last", 32'(TX_LAST), 32'(q[0].last));
                            if (TX_READY) begin
                                if (q[0].last)
                                    done++;
                                void'(q.pop_front());
                            end
                        end
                    end else begin
                        chk("idle_data", 32'(TX_DATA), 32'h0);
                        chk("idle_last", 32'(TX_LAST), 32'h0);
                    end
                end
            end
        join_none

        // reset state
        repeat (2) @(negedge CLK_10HZ);
        chk("rst_valid", 32'(TX_VALID), 32'h0);
        chk("rst_data", 32'(TX_DATA), 32'h0);
        chk("rst_last", 32'(TX_LAST), 32'h0);
        chk("rst_overrun", 32'(OVERRUN), 32'h0);
        chk("rst_frame_cnt", 32'(FRAME_CNT), 32'h0);

        // basic frame: EB 12 34 56 9B, first request 10 ticks after release
        push_byte(8'hEB, 1'b0);
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        push_byte(8'h56, 1'b0);
        push_byte(8'h9B, 1'b1);
        @(posedge CLK_10HZ);
        #1;
        RESET = 1'b1;
        ENABLE = 1'b1;
        wait_valid(n);
        chk("first_req_latency", 32'(n), 32'd10);
        wait_idle(n);
        chk("frame_len_cycles", 32'(n), 32'd5);
        chk("frame_cnt_1", 32'(FRAME_CNT), 32'd1);

        // backpressure on byte 2
        push_frame(24'h123456);
        wait_valid(n);
        chk("second_req_latency", 32'(n), 32'd5);
        @(posedge CLK_10HZ);
        @(posedge CLK_10HZ);
        #1;
        TX_READY = 1'b0;
        repeat (3) begin
            @(negedge CLK_10HZ);
            chk("stall_data", 32'(TX_DATA), 32'h34);
            chk("stall_valid", 32'(TX_VALID), 32'h1);
            @(posedge CLK_10HZ);
        end
        #1;
        TX_READY = 1'b1;
        @(posedge CLK_10HZ);
        @(negedge CLK_10HZ);
        chk("resume_data", 32'(TX_DATA), 32'h56);
        wait_idle(n);
        chk("stall_idle_bound", 32'(n < 40), 32'h1);
        chk("frame_cnt_2", 32'(FRAME_CNT), 32'd2);

        // overrun: frame stalled across the next request
        @(posedge CLK_10HZ);
        #1;
        TX_READY = 1'b0;
        TIMESTAMP = 24'h0ABCDE;
        push_frame(24'h0ABCDE);
        cnt_before = FRAME_CNT;
        wait_valid(n);
        chk("ovr_req_bound", 32'(n < 40), 32'h1);
        chk("ovr_before", 32'(OVERRUN), 32'h0);
        TIMESTAMP = 24'hFFFFFF;
        repeat (12) @(posedge CLK_10HZ);
        #1;
        TX_READY = 1'b1;
        chk("ovr_set", 32'(OVERRUN), 32'h1);
        wait_idle(n);
        chk("ovr_frame_len", 32'(n), 32'd5);
        chk("ovr_frame_cnt", 32'(FRAME_CNT), 32'(cnt_before + 8'd1));
        chk("ovr_sticky", 32'(OVERRUN), 32'h1);

        // reset mid-frame after byte 1 accepted
        TIMESTAMP = 24'h654321;
        push_frame(24'h654321);
        wait_valid(n);
        chk("post_ovr_latency", 32'(n), 32'd3);
        @(posedge CLK_10HZ);
        @(posedge CLK_10HZ);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_valid", 32'(TX_VALID), 32'h0);
        chk("async_last", 32'(TX_LAST), 32'h0);
        chk("async_data", 32'(TX_DATA), 32'h0);
        chk("async_frame_cnt", 32'(FRAME_CNT), 32'h0);
        chk("async_overrun", 32'(OVERRUN), 32'h0);
        q.delete();
        base = done;
        TIMESTAMP = 24'h13579B;
        push_frame(24'h13579B);
        repeat (2) @(posedge CLK_10HZ);
        #1;
        RESET = 1'b1;
        wait_valid(n);
        chk("rel_latency", 32'(n), 32'd10);
        wait_idle(n);
        chk("rel_frame_len", 32'(n), 32'd5);
        chk("rel_frame_cnt", 32'(FRAME_CNT), 32'd1);

        // enable held low for 30 ticks
        @(posedge CLK_10HZ);
        #1;
        ENABLE = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            @(negedge CLK_10HZ);
            if (TX_VALID)
                saw = 1'b1;
        end
        chk("disabled_no_valid", 32'(saw), 32'h0);
        TIMESTAMP = 24'hABCDEF;
        push_frame(24'hABCDEF);
        @(posedge CLK_10HZ);
        #1;
        ENABLE = 1'b1;
        wait_valid(n);
        chk("reen_latency", 32'(n), 32'd10);
        wait_idle(n);
        chk("reen_frame_len", 32'(n), 32'd5);
        chk("reen_frame_cnt", 32'(FRAME_CNT), 32'(8'(done - base)));

        // run up to the 8-bit wrap
        for (int i = 0; i < 254; i++) begin
            TIMESTAMP = 24'($urandom);
            push_frame(TIMESTAMP);
            wait_valid(n);
            chk("loop_latency", 32'(n), 32'd5);
            wait_idle(n);
            chk("loop_frame_len", 32'(n), 32'd5);
        end
        chk("wrap_model", 32'(FRAME_CNT), 32'(8'(done - base)));
        chk("wrap_frame_cnt", 32'(FRAME_CNT), 32'h00);
        chk("wrap_overrun", 32'(OVERRUN), 32'h0);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
